// File: rtl/serial_subtractor4_pkg.sv
// Shared encoding and sizing helpers for the serial add/subtract datapath family.
package serial_subtractor4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 4;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor4_full_subtractor1.sv
// Single-bit full subtractor: d = x - y - bi, with borrow-out bo.
module full_subtractor1 (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor4.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock LSB first,
// with a start/done handshake and registered result/borrow/overflow.
module serial_subtractor4
  import serial_subtractor4_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             fs_d, fs_bo;
  logic             last_step;
  logic             msb_borrow;
  logic [WIDTH-1:0] diff_next;

  full_subtractor1 u_fs (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .bi (borrow_q),
    .d  (fs_d),
    .bo (fs_bo)
  );

  assign last_step = (cnt_q == CW'(WIDTH - 1));
  // On the final step the borrow register holds the borrow into the MSB.
  assign msb_borrow = borrow_q;
  assign diff_next  = {fs_d, diff_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    borrow_d  = borrow_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    diff_sh_d = diff_sh_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    ovf_d     = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          a_sh_d    = a;
          b_sh_d    = b;
          borrow_d  = bin;
          cnt_d     = '0;
          diff_sh_d = '0;
        end
      end
      ST_RUN: begin
        borrow_d  = fs_bo;
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        diff_sh_d = diff_next;
        cnt_d     = cnt_q + CW'(1);
        if (last_step) begin
          state_d = ST_DONE;
          diff_d  = diff_next;
          bout_d  = fs_bo;
          ovf_d   = msb_borrow ^ fs_bo;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      borrow_q  <= 1'b0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      borrow_q  <= borrow_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      diff_sh_q <= diff_sh_d;
      diff_q    <= diff_d;
      bout_q    <= bout_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule
